free_list_ctrl: RTL and testbench

Allocation controller for the physical-register free pool used by the 2-wide rename stage. Holds the pool as a circular queue and grants up to two destination tags per cycle to rename slots A and B, or stalls rename when the pool cannot cover the request. Accepts up to two released tags per cycle from retire (each retiring instruction's rd_old). Reports occupancy and a sticky overflow error.

---
 rtl/free_list_ctrl.sv | 106 ++++++++++
 tb/tb_free_list_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/free_list_ctrl.sv
// Physical-register free pool for a 2-wide rename stage: a circular queue of
// tags that grants up to two tags per cycle and takes back up to two from retire.
module free_list_ctrl #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    parameter int DEPTH     = NUM_PREGS - NUM_AREGS,
    localparam int TAG_W    = $clog2(NUM_PREGS),
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_req_a,
    input  logic             alloc_req_b,
    output logic [TAG_W-1:0] alloc_tag_a,
    output logic [TAG_W-1:0] alloc_tag_b,
    output logic             alloc_gnt,
    output logic             stall,
    input  logic             free_valid_a,
    input  logic [TAG_W-1:0] free_tag_a,
    input  logic             free_valid_b,
    input  logic [TAG_W-1:0] free_tag_b,
    output logic [CNT_W-1:0] free_count,
    output logic             empty,
    output logic             overflow_err
);

    localparam int SUM_W = CNT_W + 1;

    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic             w_acc_a;
    logic             w_acc_b;
    logic [1:0]       w_n_alloc;
    logic [1:0]       w_n_free;
    logic [1:0]       w_granted;
    logic [SUM_W-1:0] w_sum;
    logic             w_drop;
    logic             w_do_free;
    logic [CNT_W-1:0] w_count_next;
    logic [PTR_W-1:0] w_head_p1;
    logic [PTR_W-1:0] w_tail_p1;
    logic [PTR_W-1:0] w_wr_b_idx;

    // Handshake: a request is served only when alloc_gnt is high in the same
    // cycle (all-or-nothing); releases need no ready, excess ones are dropped.
    assign w_n_alloc = {1'b0, alloc_req_a} + {1'b0, alloc_req_b};
    assign alloc_gnt = (r_count >= CNT_W'(w_n_alloc));
    assign stall     = (alloc_req_a | alloc_req_b) & ~alloc_gnt;
    assign w_granted = alloc_gnt ? w_n_alloc : 2'd0;

    assign w_head_p1   = r_head + PTR_W'(1);
    assign alloc_tag_a = r_mem[r_head];
    // A lone B request takes the head entry; otherwise B shows the next one.
    assign alloc_tag_b = (alloc_req_b & ~alloc_req_a) ? r_mem[r_head] : r_mem[w_head_p1];

    // Tag 0 is the permanent x0 mapping and never returns to the pool.
    assign w_acc_a  = free_valid_a & (free_tag_a != '0);
    assign w_acc_b  = free_valid_b & (free_tag_b != '0);
    assign w_n_free = {1'b0, w_acc_a} + {1'b0, w_acc_b};

    // Grant never exceeds count, so the subtraction cannot wrap.
    assign w_sum        = {1'b0, r_count} - SUM_W'(w_granted) + SUM_W'(w_n_free);
    assign w_drop       = (w_sum > SUM_W'(DEPTH));
    assign w_do_free    = (w_n_free != 2'd0) & ~w_drop;
    assign w_count_next = w_drop ? (r_count - CNT_W'(w_granted)) : w_sum[CNT_W-1:0];

    assign w_tail_p1  = r_tail + PTR_W'(1);
    assign w_wr_b_idx = w_acc_a ? w_tail_p1 : r_tail;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= TAG_W'(NUM_AREGS + i);
            end
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= CNT_W'(DEPTH);
            r_overflow <= 1'b0;
        end else begin
            r_head  <= r_head + PTR_W'(w_granted);
            r_count <= w_count_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_do_free) begin
                r_tail <= r_tail + PTR_W'(w_n_free);
                if (w_acc_a) begin
                    r_mem[r_tail] <= free_tag_a;
                end
                if (w_acc_b) begin
                    r_mem[w_wr_b_idx] <= free_tag_b;
                end
            end
        end
    end

    assign free_count   = r_count;
    assign empty        = (r_count == '0);
    assign overflow_err = r_overflow;

endmodule

// File: tb/tb_free_list_ctrl.sv
// Bench for free_list_ctrl: vector table, directed corner sequences and random
// traffic checked against a queue-based model of the free pool.
module tb_free_list_ctrl;

    logic       clk;
    logic       reset;
    logic       alloc_req_a;
    logic       alloc_req_b;
    logic [5:0] alloc_tag_a;
    logic [5:0] alloc_tag_b;
    logic       alloc_gnt;
    logic       stall;
    logic       free_valid_a;
    logic [5:0] free_tag_a;
    logic       free_valid_b;
    logic [5:0] free_tag_b;
    logic [5:0] free_count;
    logic       empty;
    logic       overflow_err;

    free_list_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_req_a  (alloc_req_a),
        .alloc_req_b  (alloc_req_b),
        .alloc_tag_a  (alloc_tag_a),
        .alloc_tag_b  (alloc_tag_b),
        .alloc_gnt    (alloc_gnt),
        .stall        (stall),
        .free_valid_a (free_valid_a),
        .free_tag_a   (free_tag_a),
        .free_valid_b (free_valid_b),
        .free_tag_b   (free_tag_b),
        .free_count   (free_count),
        .empty        (empty),
        .overflow_err (overflow_err)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: pool contents in allocation order
    int q[$];
    bit m_ovf;

    // values sampled just before the active edge of the last run_cycle
    logic       s_gnt, s_stall;
    logic [5:0] s_ta, s_tb;

    typedef struct {
        bit ra; bit rb; bit fva; int fta; bit fvb; int ftb;
        int e_gnt; int e_ta; int e_tb; int e_cnt; int e_ovf;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        for (int i = 0; i < 32; i++) q.push_back(32 + i);
        m_ovf = 1'b0;
    endfunction

    // driver: call at a negedge; returns at the next negedge
    task automatic run_cycle(input bit ra, input bit rb, input bit fva, input int fta,
                             input bit fvb, input int ftb);
        int n;
        bit m_gnt;
        int nf[$];
        alloc_req_a  = ra;
        alloc_req_b  = rb;
        free_valid_a = fva;
        free_tag_a   = 6'(fta);
        free_valid_b = fvb;
        free_tag_b   = 6'(ftb);
        #1;
        n = int'(ra) + int'(rb);
        m_gnt = (q.size() >= n);
        s_gnt = alloc_gnt; s_stall = stall; s_ta = alloc_tag_a; s_tb = alloc_tag_b;
        chk("gnt", alloc_gnt, m_gnt);
        chk("stall", stall, (ra | rb) & ~m_gnt);
        if (m_gnt && ra) chk("tag_a", alloc_tag_a, q[0]);
        if (m_gnt && rb) chk("tag_b", alloc_tag_b, ra ? q[1] : q[0]);
        @(posedge clk);
        if (m_gnt) repeat (n) void'(q.pop_front());
        if (fva && fta != 0) nf.push_back(fta);
        if (fvb && ftb != 0) nf.push_back(ftb);
        if (q.size() + nf.size() > 32) m_ovf = 1'b1;
        else foreach (nf[i]) q.push_back(nf[i]);
        #1;
        chk("free_count", free_count, q.size());
        chk("empty", empty, q.size() == 0);
        chk("overflow_err", overflow_err, m_ovf);
        @(negedge clk);
    endtask

    // asynchronous reset pulse mid-cycle; call at a negedge
    task automatic pulse_reset();
        alloc_req_a = 0; alloc_req_b = 0; free_valid_a = 0; free_valid_b = 0;
        free_tag_a = 0; free_tag_b = 0;
        #2 reset = 1'b0;
        #1;
        chk("rst_count", free_count, 32);
        chk("rst_empty", empty, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_gnt", alloc_gnt, 1);
        chk("rst_stall", stall, 0);
        chk("rst_tag_a", alloc_tag_a, 32);
        chk("rst_tag_b", alloc_tag_b, 33);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        reset = 1'b0;
        alloc_req_a = 0; alloc_req_b = 0; free_valid_a = 0; free_valid_b = 0;
        free_tag_a = 0; free_tag_b = 0;
        model_reset();
        // ra rb fva fta fvb ftb | gnt ta tb cnt ovf   (-1 = not checked)
        tbl[0] = '{0, 0, 0, 0,  0, 0,  1, -1, -1, 32, 0};
        tbl[1] = '{0, 1, 0, 0,  0, 0,  1, -1, 32, 31, 0};
        tbl[2] = '{1, 1, 0, 0,  0, 0,  1, 33, 34, 29, 0};
        tbl[3] = '{0, 0, 1, 0,  0, 0,  1, -1, -1, 29, 0};
        tbl[4] = '{1, 0, 0, 0,  1, 5,  1, 35, -1, 29, 0};
        tbl[5] = '{0, 0, 1, 7,  1, 9,  1, -1, -1, 31, 0};
        tbl[6] = '{0, 0, 1, 11, 1, 13, 1, -1, -1, 31, 1};
        tbl[7] = '{0, 1, 1, 11, 0, 0,  1, -1, 36, 31, 1};
        tbl[8] = '{1, 1, 0, 0,  0, 0,  1, 37, 38, 29, 1};
        tbl[9] = '{0, 0, 1, 0,  1, 20, 1, -1, -1, 30, 1};

        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("init_count", free_count, 32);
        chk("init_tag_a", alloc_tag_a, 32);
        chk("init_tag_b", alloc_tag_b, 33);
        chk("init_ovf", overflow_err, 0);
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_cycle(tbl[i].ra, tbl[i].rb, tbl[i].fva, tbl[i].fta, tbl[i].fvb, tbl[i].ftb);
            chk("vec_gnt", s_gnt, tbl[i].e_gnt);
            if (tbl[i].e_ta >= 0) chk("vec_tag_a", s_ta, tbl[i].e_ta);
            if (tbl[i].e_tb >= 0) chk("vec_tag_b", s_tb, tbl[i].e_tb);
            chk("vec_count", free_count, tbl[i].e_cnt);
            chk("vec_ovf", overflow_err, tbl[i].e_ovf);
        end

        // drain the pool in pairs
        pulse_reset();
        for (int k = 0; k < 16; k++) begin
            run_cycle(1, 1, 0, 0, 0, 0);
            chk("drain_a", s_ta, 32 + 2 * k);
            chk("drain_b", s_tb, 33 + 2 * k);
        end
        chk("drain_count", free_count, 0);
        chk("drain_empty", empty, 1);
        run_cycle(1, 1, 0, 0, 0, 0);
        chk("empty_stall", s_stall, 1);
        chk("empty_gnt", s_gnt, 0);

        // same-cycle release is not visible to allocation
        run_cycle(0, 0, 1, 50, 0, 0);
        chk("one_count", free_count, 1);
        run_cycle(1, 1, 1, 40, 0, 0);
        chk("bypass_stall", s_stall, 1);
        chk("bypass_count", free_count, 2);
        run_cycle(1, 1, 0, 0, 0, 0);
        chk("bypass_gnt", s_gnt, 1);
        chk("bypass_a", s_ta, 50);
        chk("bypass_b", s_tb, 40);

        // head wraps from index 31 to 0
        pulse_reset();
        for (int k = 0; k < 15; k++) run_cycle(1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 15; k++) run_cycle(0, 0, 1, 2 * k + 1, 1, 2 * k + 2);
        chk("wrap_full", free_count, 32);
        run_cycle(1, 1, 0, 0, 0, 0);
        chk("wrap_a0", s_ta, 62);
        chk("wrap_b0", s_tb, 63);
        run_cycle(1, 1, 0, 0, 0, 0);
        chk("wrap_a1", s_ta, 1);
        chk("wrap_b1", s_tb, 2);
        run_cycle(0, 0, 1, 62, 1, 63);
        chk("refill_count", free_count, 30);

        // overflow while full, then reset mid-sequence
        pulse_reset();
        run_cycle(0, 0, 1, 3, 0, 0);
        chk("ovf_set", overflow_err, 1);
        chk("ovf_count", free_count, 32);
        run_cycle(1, 0, 1, 4, 0, 0);
        chk("ovf_grant_a", s_ta, 32);
        chk("ovf_sticky", overflow_err, 1);
        pulse_reset();

        // random traffic against the model
        for (int blk = 0; blk < 3; blk++) begin
            for (int c = 0; c < 600; c++) begin
                run_cycle($urandom_range(0, 1), $urandom_range(0, 1),
                          $urandom_range(0, 9) < 4, $urandom_range(0, 63),
                          $urandom_range(0, 9) < 4, $urandom_range(0, 63));
            end
            pulse_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
